// File: rtl/rv32_decode_queue_pkg.sv
// Shared RV32 types for the fetch-to-decode queue: the instruction word,
// the pre-decoded control bundle and the entry stored in each queue slot.
package rv32_types;

   localparam int CORE_RF_NUM_READ = 2;

   typedef logic [31:0] rv_instr_t;

   typedef enum logic [1:0] {
      MEM_NONE  = 2'd0,
      MEM_LOAD  = 2'd1,
      MEM_STORE = 2'd2
   } rv_mem_op_e;

   typedef struct packed {
      logic       invalid;
      logic       register_wb;
      rv_mem_op_e mem_op;
      logic [2:0] mem_size;
      logic       alu_src_imm;
      logic       branch;
      logic       jump;
      logic       fence;
      logic       system;
   } rv_control_t;

   typedef struct packed {
      rv_instr_t                   instr;
      logic [31:0]                 pc;
      rv_control_t                 control;
      logic [CORE_RF_NUM_READ-1:0] use_rs;
   } rv_decoded_entry_t;

   // Control that does nothing: no write-back, no memory, no flow change.
   localparam rv_control_t RV_NOP_CONTROL = '{
      invalid:     1'b0,
      register_wb: 1'b0,
      mem_op:      MEM_NONE,
      mem_size:    3'b000,
      alu_src_imm: 1'b0,
      branch:      1'b0,
      jump:        1'b0,
      fence:       1'b0,
      system:      1'b0
   };

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   // Anything whose low two bits are not 11 is a 16-bit (compressed) encoding.
   function automatic logic rv_is_compressed(input rv_instr_t instr);
      return instr[1:0] != 2'b11;
   endfunction

endpackage

// File: rtl/rv32_decode_queue_decoder.sv
// Combinational RV32I pre-decoder used on the queue's enqueue path.
// Unknown opcodes and compressed encodings yield NOP control marked invalid.
module rv32_decoder
   import rv32_types::*;
(
   input  rv_instr_t                   i_instr,
   output rv_control_t                 o_control,
   output logic [CORE_RF_NUM_READ-1:0] o_use_rs
);

   logic [6:0]                  w_opcode;
   logic [2:0]                  w_funct3;
   rv_control_t                 w_control;
   logic [CORE_RF_NUM_READ-1:0] w_use_rs;
   logic                        w_unused_bits;

   assign w_opcode = i_instr[6:0];
   assign w_funct3 = i_instr[14:12];
   // Immediate and register-index fields are not needed for control decode.
   assign w_unused_bits = ^{i_instr[31:15], i_instr[11:7]};

   // Map the opcode to control flags and register-read usage.
   always_comb begin
      w_control = RV_NOP_CONTROL;
      w_use_rs  = '0;
      if (rv_is_compressed(i_instr)) begin
         w_control.invalid = 1'b1;
      end else begin
         case (w_opcode)
            OPC_LUI, OPC_AUIPC: begin
               w_control.register_wb = 1'b1;
               w_control.alu_src_imm = 1'b1;
            end
            OPC_JAL: begin
               w_control.register_wb = 1'b1;
               w_control.jump        = 1'b1;
            end
            OPC_JALR: begin
               w_control.register_wb = 1'b1;
               w_control.jump        = 1'b1;
               w_control.alu_src_imm = 1'b1;
               w_use_rs[0]           = 1'b1;
            end
            OPC_BRANCH: begin
               w_control.branch = 1'b1;
               w_use_rs[0]      = 1'b1;
               w_use_rs[1]      = 1'b1;
            end
            OPC_LOAD: begin
               w_control.register_wb = 1'b1;
               w_control.mem_op      = MEM_LOAD;
               w_control.mem_size    = w_funct3;
               w_control.alu_src_imm = 1'b1;
               w_use_rs[0]           = 1'b1;
            end
            OPC_STORE: begin
               w_control.mem_op      = MEM_STORE;
               w_control.mem_size    = w_funct3;
               w_control.alu_src_imm = 1'b1;
               w_use_rs[0]           = 1'b1;
               w_use_rs[1]           = 1'b1;
            end
            OPC_OP_IMM: begin
               w_control.register_wb = 1'b1;
               w_control.alu_src_imm = 1'b1;
               w_use_rs[0]           = 1'b1;
            end
            OPC_OP: begin
               w_control.register_wb = 1'b1;
               w_use_rs[0]           = 1'b1;
               w_use_rs[1]           = 1'b1;
            end
            OPC_MISC_MEM: begin
               w_control.fence = 1'b1;
            end
            OPC_SYSTEM: begin
               w_control.system = 1'b1;
            end
            default: begin
               w_control.invalid = 1'b1;
            end
         endcase
      end
   end

   assign o_control = w_control;
   assign o_use_rs  = w_use_rs;

endmodule

// File: rtl/rv32_decode_queue.sv
// Fetch-to-decode FIFO: instructions are pre-decoded as they are enqueued and
// the head entry is presented with one cycle of latency from an empty queue.
// DEPTH must be a power of two (>= 2) so the pointers wrap by overflow.
module rv32_decode_queue
   import rv32_types::*;
#(
   parameter int DEPTH = 4,
   parameter int SAT_W = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          flush,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  rv_instr_t                     in_instr,
   input  logic [31:0]                   in_pc,
   output logic                          out_valid,
   input  logic                          out_ready,
   output rv_instr_t                     out_instr,
   output logic [31:0]                   out_pc,
   output rv_control_t                   out_control,
   output logic [CORE_RF_NUM_READ-1:0]   out_use_rs,
   output logic [$clog2(DEPTH+1)-1:0]    count,
   output logic [SAT_W-1:0]              invalid_count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [PTR_W-1:0]            r_wr_ptr;
   logic [PTR_W-1:0]            r_rd_ptr;
   logic [CNT_W-1:0]            r_count;
   logic [SAT_W-1:0]            r_invalid_count;
   rv_decoded_entry_t           r_mem [DEPTH];

   rv_control_t                 w_dec_control;
   logic [CORE_RF_NUM_READ-1:0] w_dec_use_rs;
   rv_decoded_entry_t           w_entry;
   rv_decoded_entry_t           w_head;
   logic                        w_enq;
   logic                        w_deq;

   rv32_decoder u_decoder (
      .i_instr   (in_instr),
      .o_control (w_dec_control),
      .o_use_rs  (w_dec_use_rs)
   );

   assign w_entry = '{instr: in_instr, pc: in_pc, control: w_dec_control, use_rs: w_dec_use_rs};

   // Readiness is a function of registered occupancy, flush and reset only.
   assign in_ready  = !rst && !flush && (r_count != CNT_W'(DEPTH));
   assign out_valid = (r_count != '0);
   assign count     = r_count;
   assign invalid_count = r_invalid_count;

   // A flush cancels both transfers of the cycle it is asserted in.
   assign w_enq = in_valid && in_ready;
   assign w_deq = out_valid && out_ready && !flush;

   // Pointer and occupancy tracking; flush empties the queue and rewinds pointers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_deq) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_enq, w_deq})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage holds decoded results; contents are don't-care until written.
   always_ff @(posedge clk) begin
      if (w_enq) r_mem[r_wr_ptr] <= w_entry;
   end

   // Count dequeued invalid instructions, sticking at all-ones; flush keeps it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_invalid_count <= '0;
      end else if (w_deq && out_control.invalid && (r_invalid_count != '1)) begin
         r_invalid_count <= r_invalid_count + SAT_W'(1);
      end
   end

   assign w_head = r_mem[r_rd_ptr];

   // Present the head entry, or a clean NOP when the queue is empty.
   always_comb begin
      out_instr   = '0;
      out_pc      = '0;
      out_control = RV_NOP_CONTROL;
      out_use_rs  = '0;
      if (out_valid) begin
         out_instr   = w_head.instr;
         out_pc      = w_head.pc;
         out_control = w_head.control;
         out_use_rs  = w_head.use_rs;
      end
   end

endmodule

// File: tb/tb_rv32_decode_queue.sv
// Directed bench for rv32_decode_queue: a vector table for the fill/drain,
// flush, decode and invalid-instruction paths, plus hand-written sequences
// for counter saturation, streaming throughput and asynchronous reset.
module tb_rv32_decode_queue;
   import rv32_types::*;

   localparam logic [31:0] A1 = 32'h00100093; // addi x1,x0,1
   localparam logic [31:0] A2 = 32'h00200113; // addi x2,x0,2
   localparam logic [31:0] A3 = 32'h00300193; // addi x3,x0,3
   localparam logic [31:0] A4 = 32'h00400213; // addi x4,x0,4
   localparam logic [31:0] LW = 32'h00812283; // lw x5,8(x2)
   localparam logic [31:0] C1 = 32'h00000001; // compressed encoding
   localparam logic [31:0] CU = 32'h0000000B; // custom-0

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   rv_control_t out_control;
   logic [1:0]  out_use_rs;
   logic [2:0]  count;
   logic [15:0] invalid_count;

   logic        unused_sat_in_ready;
   logic        sat_out_valid;
   logic [31:0] unused_sat_out_instr;
   logic [31:0] unused_sat_out_pc;
   rv_control_t unused_sat_out_control;
   logic [1:0]  unused_sat_out_use_rs;
   logic [2:0]  sat_count;
   logic [1:0]  sat_invalid_count;

   int n_checks = 0;
   int n_errors = 0;

   rv32_decode_queue #(.DEPTH(4), .SAT_W(16)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
      .out_control(out_control), .out_use_rs(out_use_rs),
      .count(count), .invalid_count(invalid_count)
   );

   rv32_decode_queue #(.DEPTH(4), .SAT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(unused_sat_in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(sat_out_valid), .out_ready(out_ready), .out_instr(unused_sat_out_instr),
      .out_pc(unused_sat_out_pc), .out_control(unused_sat_out_control),
      .out_use_rs(unused_sat_out_use_rs),
      .count(sat_count), .invalid_count(sat_invalid_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        fl;
      logic        iv;
      logic [31:0] ins;
      logic [31:0] pc;
      logic        ordy;
      logic [2:0]  e_cnt;
      logic        e_ov;
      logic [31:0] e_ins;
      logic [31:0] e_pc;
      logic        e_inv;
      logic        e_wb;
      logic [1:0]  e_mem;
      logic [1:0]  e_use;
      logic        e_ir;
      logic [15:0] e_ic;
   } vec_t;

   function automatic vec_t mk(
      input logic fl, input logic iv, input logic [31:0] ins, input logic [31:0] pc,
      input logic ordy, input logic [2:0] e_cnt, input logic e_ov, input logic [31:0] e_ins,
      input logic [31:0] e_pc, input logic e_inv, input logic e_wb, input logic [1:0] e_mem,
      input logic [1:0] e_use, input logic e_ir, input logic [15:0] e_ic);
      vec_t v;
      v.fl = fl; v.iv = iv; v.ins = ins; v.pc = pc; v.ordy = ordy;
      v.e_cnt = e_cnt; v.e_ov = e_ov; v.e_ins = e_ins; v.e_pc = e_pc;
      v.e_inv = e_inv; v.e_wb = e_wb; v.e_mem = e_mem; v.e_use = e_use;
      v.e_ir = e_ir; v.e_ic = e_ic;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   vec_t vecs [20];
   int   n_deq;

   initial begin
      // Table: inputs held across one rising edge, expectations sampled #1 later.
      //          fl iv ins    pc       or cnt ov e_ins  e_pc     inv wb mem    use    ir ic
      vecs[0]  = mk(0, 1, A1,    32'h00,  0, 1, 1, A1,    32'h00,  0, 1, 2'd0, 2'b01, 1, 0);
      vecs[1]  = mk(0, 1, A2,    32'h04,  0, 2, 1, A1,    32'h00,  0, 1, 2'd0, 2'b01, 1, 0);
      vecs[2]  = mk(0, 1, A3,    32'h08,  0, 3, 1, A1,    32'h00,  0, 1, 2'd0, 2'b01, 1, 0);
      vecs[3]  = mk(0, 1, A4,    32'h0C,  0, 4, 1, A1,    32'h00,  0, 1, 2'd0, 2'b01, 0, 0);
      vecs[4]  = mk(0, 1, A1,    32'h10,  0, 4, 1, A1,    32'h00,  0, 1, 2'd0, 2'b01, 0, 0);
      vecs[5]  = mk(0, 0, 32'h0, 32'h0,   1, 3, 1, A2,    32'h04,  0, 1, 2'd0, 2'b01, 1, 0);
      vecs[6]  = mk(0, 0, 32'h0, 32'h0,   1, 2, 1, A3,    32'h08,  0, 1, 2'd0, 2'b01, 1, 0);
      vecs[7]  = mk(0, 0, 32'h0, 32'h0,   1, 1, 1, A4,    32'h0C,  0, 1, 2'd0, 2'b01, 1, 0);
      vecs[8]  = mk(0, 0, 32'h0, 32'h0,   1, 0, 0, 32'h0, 32'h0,   0, 0, 2'd0, 2'b00, 1, 0);
      vecs[9]  = mk(0, 0, 32'h0, 32'h0,   1, 0, 0, 32'h0, 32'h0,   0, 0, 2'd0, 2'b00, 1, 0);
      vecs[10] = mk(0, 1, A1,    32'h20,  0, 1, 1, A1,    32'h20,  0, 1, 2'd0, 2'b01, 1, 0);
      vecs[11] = mk(0, 1, A2,    32'h24,  0, 2, 1, A1,    32'h20,  0, 1, 2'd0, 2'b01, 1, 0);
      vecs[12] = mk(0, 1, A3,    32'h28,  0, 3, 1, A1,    32'h20,  0, 1, 2'd0, 2'b01, 1, 0);
      vecs[13] = mk(1, 1, A4,    32'h2C,  1, 0, 0, 32'h0, 32'h0,   0, 0, 2'd0, 2'b00, 0, 0);
      vecs[14] = mk(0, 0, 32'h0, 32'h0,   0, 0, 0, 32'h0, 32'h0,   0, 0, 2'd0, 2'b00, 1, 0);
      vecs[15] = mk(0, 1, LW,    32'h100, 0, 1, 1, LW,    32'h100, 0, 1, 2'd1, 2'b01, 1, 0);
      vecs[16] = mk(0, 0, 32'h0, 32'h0,   1, 0, 0, 32'h0, 32'h0,   0, 0, 2'd0, 2'b00, 1, 0);
      vecs[17] = mk(0, 1, C1,    32'h200, 0, 1, 1, C1,    32'h200, 1, 0, 2'd0, 2'b00, 1, 0);
      vecs[18] = mk(0, 1, CU,    32'h204, 1, 1, 1, CU,    32'h204, 1, 0, 2'd0, 2'b00, 1, 1);
      vecs[19] = mk(0, 0, 32'h0, 32'h0,   1, 0, 0, 32'h0, 32'h0,   0, 0, 2'd0, 2'b00, 1, 2);

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
      repeat (2) step();

      // Reset state while rst is still high.
      check("reset count", 64'(count), 64'd0);
      check("reset out_valid", 64'(out_valid), 64'd0);
      check("reset in_ready", 64'(in_ready), 64'd0);
      check("reset invalid_count", 64'(invalid_count), 64'd0);
      check("reset out_control", 64'(out_control), 64'(RV_NOP_CONTROL));
      rst = 1'b0;
      #1;
      check("post-reset in_ready", 64'(in_ready), 64'd1);
      $display("reset released");

      for (int i = 0; i < 20; i++) begin
         flush = vecs[i].fl; in_valid = vecs[i].iv; in_instr = vecs[i].ins;
         in_pc = vecs[i].pc; out_ready = vecs[i].ordy;
         step();
         check($sformatf("v%0d count", i), 64'(count), 64'(vecs[i].e_cnt));
         check($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
         check($sformatf("v%0d out_instr", i), 64'(out_instr), 64'(vecs[i].e_ins));
         check($sformatf("v%0d out_pc", i), 64'(out_pc), 64'(vecs[i].e_pc));
         check($sformatf("v%0d invalid", i), 64'(out_control.invalid), 64'(vecs[i].e_inv));
         check($sformatf("v%0d register_wb", i), 64'(out_control.register_wb), 64'(vecs[i].e_wb));
         check($sformatf("v%0d mem_op", i), 64'(out_control.mem_op), 64'(vecs[i].e_mem));
         check($sformatf("v%0d use_rs", i), 64'(out_use_rs), 64'(vecs[i].e_use));
         check($sformatf("v%0d in_ready", i), 64'(in_ready), 64'(vecs[i].e_ir));
         check($sformatf("v%0d invalid_count", i), 64'(invalid_count), 64'(vecs[i].e_ic));
         $display("vec %0d: fl=%0d iv=%0d pc=%0h or=%0d -> count=%0d head_pc=%0h",
                  i, vecs[i].fl, vecs[i].iv, vecs[i].pc, vecs[i].ordy, count, out_pc);
      end
      check("sat invalid_count after table", 64'(sat_invalid_count), 64'd2);

      // Saturation: three more invalid dequeues; 2-bit counter must stick at 3.
      for (int k = 0; k < 3; k++) begin
         flush = 1'b0; in_valid = 1'b1; in_instr = C1; in_pc = 32'h300 + 32'(4 * k); out_ready = 1'b0;
         step();
         in_valid = 1'b0; out_ready = 1'b1;
         step();
         check($sformatf("sat%0d wide invalid_count", k), 64'(invalid_count), 64'(3 + k));
         check($sformatf("sat%0d narrow invalid_count", k), 64'(sat_invalid_count), 64'd3);
         $display("sat %0d: invalid_count=%0d narrow=%0d", k, invalid_count, sat_invalid_count);
      end

      // Streaming: enqueue and dequeue every cycle for 20 cycles.
      n_deq = 0;
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1; out_ready = 1'b1; in_instr = A2; in_pc = 32'h400 + 32'(4 * i);
         #1;
         if (out_valid && out_ready) n_deq++;
         step();
         check($sformatf("stream%0d count", i), 64'(count), 64'd1);
         check($sformatf("stream%0d out_pc", i), 64'(out_pc), 64'(32'h400 + 32'(4 * i)));
         $display("stream %0d: count=%0d head_pc=%0h", i, count, out_pc);
      end
      check("stream dequeues", 64'(n_deq), 64'd19);
      in_valid = 1'b0;
      step();
      check("stream drain count", 64'(count), 64'd0);

      // Asynchronous reset between edges with two entries queued.
      out_ready = 1'b0; in_valid = 1'b1; in_instr = A1; in_pc = 32'h500;
      step();
      in_pc = 32'h504;
      step();
      in_valid = 1'b0;
      check("pre-reset count", 64'(count), 64'd2);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("async count", 64'(count), 64'd0);
      check("async out_valid", 64'(out_valid), 64'd0);
      check("async invalid_count", 64'(invalid_count), 64'd0);
      check("async narrow invalid_count", 64'(sat_invalid_count), 64'd0);
      check("async narrow count", 64'(sat_count), 64'd0);
      check("async in_ready", 64'(in_ready), 64'd0);
      $display("async reset: count=%0d out_valid=%0d", count, out_valid);
      #1;
      rst = 1'b0;
      step();
      check("after reset count", 64'(count), 64'd0);
      check("after reset in_ready", 64'(in_ready), 64'd1);
      check("after reset narrow out_valid", 64'(sat_out_valid), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rv32_decode_queue.md
RV32_DECODE_QUEUE -- requirements
Module: rv32_decode_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; SHALL be a power of 2 and at least 2.
REQ-002 Parameter SAT_W, default 16, width of the saturating invalid-instruction counter.
REQ-003 clk  in  1  single core clock; all state SHALL be on its rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 flush  in  1  synchronous discard of all queued entries.
REQ-006 in_valid  in  1  fetch offers an instruction.
REQ-007 in_ready  out  1  queue accepts an instruction this cycle.
REQ-008 in_instr  in  rv_instr_t  fetched instruction word.
REQ-009 in_pc  in  32  PC of in_instr.
REQ-010 out_valid  out  1  head entry is valid.
REQ-011 out_ready  in  1  downstream consumes the head entry.
REQ-012 out_instr  out  rv_instr_t  head instruction.
REQ-013 out_pc  out  32  head PC.
REQ-014 out_control  out  rv_control_t  pre-decoded head control.
REQ-015 out_use_rs  out  logic [CORE_RF_NUM_READ]  pre-decoded register-use flags of head.
REQ-016 count  out  $clog2(DEPTH+1)  current occupancy.
REQ-017 invalid_count  out  SAT_W  number of dequeued invalid instructions.

Function
REQ-018 Enqueue SHALL occur when in_valid && in_ready; dequeue SHALL occur when out_valid && out_ready.
REQ-019 in_ready SHALL equal !flush && (count != DEPTH); it SHALL NOT depend combinationally on out_ready.
REQ-020 out_valid SHALL equal (count != 0), driven from registered state only.
REQ-021 Decode SHALL occur at enqueue; each entry SHALL store instr, pc, control and use_rs.
REQ-022 Latency: an instruction enqueued into an empty queue at cycle N SHALL appear on out_* with out_valid=1 at cycle N+1.
REQ-023 When in_instr[1:0] != 2'b11 (compressed encoding), the stored control SHALL be NOP control with invalid=1, register_wb=0, and all use_rs SHALL be 0.
REQ-024 Simultaneous enqueue and dequeue SHALL leave count unchanged and advance both pointers.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH.
REQ-026 Entries SHALL be dequeued in FIFO order.
REQ-027 flush SHALL have highest priority: next cycle count=0, both pointers=0, out_valid=0; an enqueue or dequeue in the flush cycle SHALL have no effect.
REQ-028 When out_valid=0, out_control SHALL be the NOP control, out_use_rs all 0, and out_instr and out_pc 0.
REQ-029 invalid_count SHALL increment by 1 on each dequeue whose out_control.invalid=1, SHALL saturate at all-ones, and SHALL NOT be cleared by flush.

Reset
REQ-030 Asserting rst SHALL immediately clear count, pointers, out_valid and invalid_count, including mid-transfer; entry storage need not be reset.
REQ-031 While rst is high, in_ready SHALL be 0.

Structure
REQ-032 Package rv32_types SHALL hold the rv_decoded_entry_t struct (instr, pc, control, use_rs); DEPTH and SAT_W stay module parameters.
REQ-033 A single rv32_decoder instance on the enqueue path SHALL be the only sub-module; storage and pointers SHALL be local.

Verification
REQ-034 Fill/drain: DEPTH=4, enqueue 4 instructions (addi x1..x4) with out_ready=0 -> in_ready=0 and count=4; then out_ready=1 -> the 4 instructions appear in order on 4 consecutive cycles.
REQ-035 Streaming: in_valid=out_ready=1 continuously for 20 cycles -> count stays 1 after the first cycle and throughput is 1 instruction per cycle.
REQ-036 Flush: flush asserted with count=3 while in_valid=1 -> next cycle count=0, out_valid=0, and the offered instruction is dropped.
REQ-037 Compressed/invalid: enqueue 0x00000001, then custom-0 0x0000000B, each dequeued -> out_control.invalid=1 and invalid_count=2; force saturation with SAT_W=2 -> counter holds 3.
REQ-038 Async reset mid-operation: rst pulsed between clock edges with count=2 -> out_valid, count and invalid_count are 0 before the next edge.
REQ-039 Decode passthrough: lw x5,8(x2) at pc 0x100 -> out_pc=0x100, mem_op load, register_wb=1, use_rs[0]=1, use_rs[1]=0.
